// File: rtl/axi_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_pkg
//  Purpose  : Shared types for the I/D cache AXI read-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package axi_pkg;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ar_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/axi_read_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_read_arbiter_if
//  Purpose  : Bundles both cache request/return channels, the AXI read port
//             and the busy/error flags around the read arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface axi_read_arbiter_if #(
    parameter int DATA_W = 64
);
    import axi_pkg::*;

    logic              i_arvalid;
    logic              d_arvalid;
    axi_ar_t           i_ar;
    axi_ar_t           d_ar;
    logic              i_arready;
    logic              d_arready;
    logic              i_rvalid;
    logic              d_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic [DATA_W-1:0] d_rdata;
    logic              i_rlast;
    logic              d_rlast;
    logic              i_rready;
    logic              d_rready;

    logic              m_arvalid;
    axi_ar_t           m_ar;
    logic              m_arready;
    logic              m_rvalid;
    logic              m_rlast;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rready;

    logic              icache_reading;
    logic              dcache_reading;
    logic              protocol_err;

    // Arbiter side
    modport slave (
        input  i_arvalid, d_arvalid, i_ar, d_ar, i_rready, d_rready,
        input  m_arready, m_rvalid, m_rlast, m_rdata,
        output i_arready, d_arready, i_rvalid, d_rvalid, i_rdata, d_rdata,
        output i_rlast, d_rlast,
        output m_arvalid, m_ar, m_rready,
        output icache_reading, dcache_reading, protocol_err
    );

    // Caches plus AXI slave side
    modport master (
        output i_arvalid, d_arvalid, i_ar, d_ar, i_rready, d_rready,
        output m_arready, m_rvalid, m_rlast, m_rdata,
        input  i_arready, d_arready, i_rvalid, d_rvalid, i_rdata, d_rdata,
        input  i_rlast, d_rlast,
        input  m_arvalid, m_ar, m_rready,
        input  icache_reading, dcache_reading, protocol_err
    );

endinterface
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_read_arbiter
//  Purpose  : Shares one AXI read port between icache and dcache, one burst
//             at a time, with D priority and bounded I starvation.
//  Revision : 1.0  initial release
// ============================================================================
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4      // must be >= 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    axi_read_arbiter_if.slave bus
);

    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e              r_state;
    grant_e                  r_grant;
    logic [c_STARVE_W-1:0]   r_starve_cnt;
    logic [7:0]              r_beat_cnt;
    axi_ar_t                 r_ar;
    logic                    r_protocol_err;

    arb_state_e              w_state_nxt;
    grant_e                  w_grant_nxt;
    logic [c_STARVE_W-1:0]   w_starve_nxt;
    logic [7:0]              w_beat_nxt;
    axi_ar_t                 w_ar_nxt;
    logic                    w_err_nxt;

    grant_e                  w_winner;
    logic                    w_starved;
    logic                    w_i_arready;
    logic                    w_d_arready;
    logic                    w_m_arvalid;
    logic                    w_m_rready;
    logic                    w_r_hs;
    logic                    w_own_i;
    logic                    w_own_d;
    logic [DATA_W-1:0]       w_rdata;

    function automatic grant_e pick_winner(input logic ireq, input logic dreq,
                                           input logic starved);
        if (ireq && (!dreq || starved)) begin
            return GNT_I;
        end
        return GNT_D;
    endfunction

    assign w_starved = (r_starve_cnt == c_STARVE_W'(STARVE_LIMIT));
    assign w_winner  = pick_winner(bus.i_arvalid, bus.d_arvalid, w_starved);
    assign w_r_hs    = bus.m_rvalid && w_m_rready;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_starve_nxt = r_starve_cnt;
        w_beat_nxt   = r_beat_cnt;
        w_ar_nxt     = r_ar;
        w_err_nxt    = r_protocol_err;
        w_i_arready  = 1'b0;
        w_d_arready  = 1'b0;
        w_m_arvalid  = 1'b0;
        w_m_rready   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.i_arvalid || bus.d_arvalid) begin
                    w_state_nxt = ADDR;
                    w_grant_nxt = w_winner;
                    if (w_winner == GNT_I) begin
                        w_i_arready  = 1'b1;
                        w_ar_nxt     = bus.i_ar;
                        w_starve_nxt = '0;
                    end else begin
                        w_d_arready = 1'b1;
                        w_ar_nxt    = bus.d_ar;
                        if (bus.i_arvalid && !w_starved) begin
                            w_starve_nxt = r_starve_cnt + c_STARVE_W'(1);
                        end
                    end
                end
                if (bus.m_rvalid) begin
                    w_err_nxt = 1'b1;
                end
            end

            ADDR: begin
                w_m_arvalid = 1'b1;
                if (bus.m_arready) begin
                    w_state_nxt = DATA;
                    w_beat_nxt  = r_ar.len;
                end
                if (bus.m_rvalid) begin
                    w_err_nxt = 1'b1;
                end
            end

            DATA: begin
                w_m_rready = (r_grant == GNT_I) ? bus.i_rready : bus.d_rready;
                if (bus.m_rvalid && w_m_rready) begin
                    w_beat_nxt = r_beat_cnt - 8'd1;
                    // The burst always closes on rlast, even a malformed one.
                    if (bus.m_rlast) begin
                        w_state_nxt = IDLE;
                        if (r_beat_cnt != 8'd0) begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (r_beat_cnt == 8'd0) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_grant        <= GNT_D;
            r_starve_cnt   <= '0;
            r_beat_cnt     <= 8'd0;
            r_ar           <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant        <= w_grant_nxt;
            r_starve_cnt   <= w_starve_nxt;
            r_beat_cnt     <= w_beat_nxt;
            r_ar           <= w_ar_nxt;
            r_protocol_err <= w_err_nxt;
        end
    end

    assign w_own_i = (r_state == DATA) && (r_grant == GNT_I) && !reset;
    assign w_own_d = (r_state == DATA) && (r_grant == GNT_D) && !reset;
    assign w_rdata = bus.m_rdata;

    // Handshake outputs are masked while reset is held so nothing leaks out.
    assign bus.i_arready      = w_i_arready && !reset;
    assign bus.d_arready      = w_d_arready && !reset;
    assign bus.m_arvalid      = w_m_arvalid && !reset;
    assign bus.m_rready       = w_m_rready && !reset;
    assign bus.m_ar           = r_ar;

    assign bus.i_rvalid       = w_own_i && bus.m_rvalid;
    assign bus.d_rvalid       = w_own_d && bus.m_rvalid;
    assign bus.i_rlast        = w_own_i && bus.m_rlast;
    assign bus.d_rlast        = w_own_d && bus.m_rlast;
    assign bus.i_rdata        = w_rdata;
    assign bus.d_rdata        = w_rdata;

    assign bus.icache_reading = (r_state != IDLE) && (r_grant == GNT_I);
    assign bus.dcache_reading = (r_state != IDLE) && (r_grant == GNT_D);
    assign bus.protocol_err   = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_read_arbiter
//  Purpose  : Directed scoreboard bench for axi_read_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_read_arbiter;
    import axi_pkg::*;

    localparam int DATA_W       = 64;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        grant_e      owner;
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_read_arbiter_if #(.DATA_W(DATA_W)) bus ();

    axi_read_arbiter #(
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    beat_t   exp_q[$];
    axi_ar_t i_req_q[$];
    axi_ar_t d_req_q[$];
    grant_e  grant_log[$];
    int      grant_cyc[$];
    int      rlast_cyc_q[$];
    int      cyc        = 0;
    int      errors     = 0;
    int      checks     = 0;
    int      ar_wait    = 0;
    int      force_last = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input axi_ar_t ar, input int idx);
        return {ar.addr[55:0], 8'(idx)};
    endfunction

    function automatic axi_ar_t mk_ar(input logic [63:0] addr, input logic [7:0] len);
        axi_ar_t ar;
        ar.addr  = addr;
        ar.len   = len;
        ar.size  = 3'd3;
        ar.burst = 2'b01;
        return ar;
    endfunction

    task automatic push_burst(input grant_e owner, input axi_ar_t ar, input int nbeats);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b.owner = owner;
            b.data  = beat_data(ar, k);
            b.last  = (k == nbeats - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_grant(input grant_e who, input string tag);
        logic seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = (who == GNT_I) ? bus.i_arready : bus.d_arready;
        end
        check1(tag, seen, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        logic done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (i_req_q.size() == 0) && (d_req_q.size() == 0)
                   && !bus.icache_reading && !bus.dcache_reading;
        end
        check1(tag, done, 1'b1);
    endtask

    task automatic wait_exp_size(input int n, input string tag);
        logic ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge clk);
            ok = (exp_q.size() <= n);
        end
        check1(tag, ok, 1'b1);
    endtask

    task automatic take_beat(input grant_e who, input logic [63:0] data, input logic last);
        beat_t e;
        check1("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check64("beat_owner", 64'(who), 64'(e.owner));
            check64("beat_data", data, e.data);
            check1("beat_last", last, e.last);
            if (last) rlast_cyc_q.push_back(cyc);
        end
    endtask

    // I requester: presents the head of its queue until accepted
    initial begin
        logic hs;
        bus.i_arvalid = 1'b0;
        bus.i_ar      = '0;
        forever begin
            @(negedge clk);
            hs = bus.i_arvalid && bus.i_arready;
            if (hs) begin
                grant_log.push_back(GNT_I);
                grant_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (hs && i_req_q.size() > 0) void'(i_req_q.pop_front());
            bus.i_arvalid = (i_req_q.size() > 0);
            bus.i_ar      = (i_req_q.size() > 0) ? i_req_q[0] : '0;
        end
    end

    // D requester
    initial begin
        logic hs;
        bus.d_arvalid = 1'b0;
        bus.d_ar      = '0;
        forever begin
            @(negedge clk);
            hs = bus.d_arvalid && bus.d_arready;
            if (hs) begin
                grant_log.push_back(GNT_D);
                grant_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (hs && d_req_q.size() > 0) void'(d_req_q.pop_front());
            bus.d_arvalid = (d_req_q.size() > 0);
            bus.d_ar      = (d_req_q.size() > 0) ? d_req_q[0] : '0;
        end
    end

    // AXI slave model: optional AR stall, then len+1 beats (or early rlast)
    initial begin
        logic    ar_hs, r_hs, r_last_s;
        axi_ar_t cap, cur;
        int      beat, nb, waited;
        logic    active;
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rlast   = 1'b0;
        bus.m_rdata   = '0;
        active = 1'b0; beat = 0; nb = 0; waited = 0; cur = '0;
        forever begin
            @(negedge clk);
            ar_hs    = bus.m_arvalid && bus.m_arready;
            r_hs     = bus.m_rvalid && bus.m_rready;
            r_last_s = bus.m_rlast;
            cap      = bus.m_ar;
            @(posedge clk);
            #1;
            if (reset) begin
                active = 1'b0; beat = 0; waited = 0;
                bus.m_arready = 1'b0;
                bus.m_rvalid  = 1'b0;
                bus.m_rlast   = 1'b0;
                continue;
            end
            if (r_hs) begin
                beat++;
                if (r_last_s) active = 1'b0;
            end
            if (ar_hs) begin
                bus.m_arready = 1'b0;
                waited = 0;
                active = 1'b1;
                cur    = cap;
                nb     = int'(cap.len) + 1;
                beat   = 0;
            end else if (!active && bus.m_arvalid && !bus.m_arready) begin
                if (waited >= ar_wait) bus.m_arready = 1'b1;
                else waited++;
            end
            bus.m_rvalid = active;
            bus.m_rdata  = beat_data(cur, beat);
            bus.m_rlast  = active && ((beat == nb - 1) || (beat == force_last));
        end
    end

    // Return-path monitor against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.i_rvalid || bus.d_rvalid)
                    check1("rvalid_exclusive", bus.i_rvalid && bus.d_rvalid, 1'b0);
                if (bus.i_rvalid && bus.i_rready) take_beat(GNT_I, bus.i_rdata, bus.i_rlast);
                if (bus.d_rvalid && bus.d_rready) take_beat(GNT_D, bus.d_rdata, bus.d_rlast);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        axi_ar_t ar_i, ar_d;
        grant_e  exp_g [6];

        reset        = 1'b1;
        bus.i_rready = 1'b1;
        bus.d_rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_icache_reading", bus.icache_reading, 1'b0);
        check1("rst_dcache_reading", bus.dcache_reading, 1'b0);
        check1("rst_m_arvalid", bus.m_arvalid, 1'b0);
        check1("rst_m_rready", bus.m_rready, 1'b0);
        check1("rst_protocol_err", bus.protocol_err, 1'b0);
        check1("rst_m_ar_zero", bus.m_ar == '0, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Lone I burst of 8 beats
        ar_i = mk_ar(64'h1000, 8'd7);
        @(negedge clk);
        #1;
        push_burst(GNT_I, ar_i, 8);
        i_req_q.push_back(ar_i);
        wait_grant(GNT_I, "t1_i_arready");
        check1("t1_m_arvalid_at_T", bus.m_arvalid, 1'b0);
        @(negedge clk);
        check1("t1_m_arvalid_at_T1", bus.m_arvalid, 1'b1);
        check64("t1_m_ar_addr", bus.m_ar.addr, 64'h1000);
        check1("t1_arready_pulse", bus.i_arready, 1'b0);
        check1("t1_icache_reading", bus.icache_reading, 1'b1);
        wait_drain("t1_drain");
        check1("t1_idle_icache", bus.icache_reading, 1'b0);
        check1("t1_no_err", bus.protocol_err, 1'b0);

        // Simultaneous requests: D first, I right after D's rlast
        grant_log.delete(); grant_cyc.delete(); rlast_cyc_q.delete();
        ar_d = mk_ar(64'h2000, 8'd1);
        ar_i = mk_ar(64'h3000, 8'd1);
        @(negedge clk);
        #1;
        push_burst(GNT_D, ar_d, 2);
        push_burst(GNT_I, ar_i, 2);
        d_req_q.push_back(ar_d);
        i_req_q.push_back(ar_i);
        wait_grant(GNT_D, "t2_d_arready");
        check1("t2_i_not_granted", bus.i_arready, 1'b0);
        @(negedge clk);
        check1("t2_dcache_reading", bus.dcache_reading, 1'b1);
        check1("t2_icache_idle", bus.icache_reading, 1'b0);
        wait_drain("t2_drain");
        check64("t2_grant1", 64'(grant_log[1]), 64'(GNT_I));
        check64("t2_regrant_cyc", 64'(grant_cyc[1]), 64'(rlast_cyc_q[0] + 1));

        // Starvation bound: D,D,D,D,I,D
        grant_log.delete();
        ar_i = mk_ar(64'h5000, 8'd0);
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) push_burst(GNT_D, mk_ar(64'h4000 + 64'(k) * 64'h100, 8'd0), 1);
        push_burst(GNT_I, ar_i, 1);
        push_burst(GNT_D, mk_ar(64'h4400, 8'd0), 1);
        for (int k = 0; k < 5; k++) d_req_q.push_back(mk_ar(64'h4000 + 64'(k) * 64'h100, 8'd0));
        i_req_q.push_back(ar_i);
        wait_drain("t3_drain");
        exp_g = '{GNT_D, GNT_D, GNT_D, GNT_D, GNT_I, GNT_D};
        check64("t3_grant_count", 64'(grant_log.size()), 64'd6);
        for (int k = 0; k < 6; k++)
            check64($sformatf("t3_grant%0d", k), 64'(grant_log[k]), 64'(exp_g[k]));

        // Starve counter cleared by the I grant: D wins again
        grant_log.delete();
        ar_d = mk_ar(64'h6000, 8'd0);
        ar_i = mk_ar(64'h7000, 8'd0);
        @(negedge clk);
        #1;
        push_burst(GNT_D, ar_d, 1);
        push_burst(GNT_I, ar_i, 1);
        d_req_q.push_back(ar_d);
        i_req_q.push_back(ar_i);
        wait_drain("t3b_drain");
        check64("t3b_first_grant", 64'(grant_log[0]), 64'(GNT_D));

        // Slave stalls AR for 5 cycles
        grant_log.delete();
        ar_wait = 5;
        ar_d = mk_ar(64'h8000, 8'd1);
        ar_i = mk_ar(64'h9000, 8'd1);
        @(negedge clk);
        #1;
        push_burst(GNT_D, ar_d, 2);
        push_burst(GNT_I, ar_i, 2);
        d_req_q.push_back(ar_d);
        i_req_q.push_back(ar_i);
        wait_grant(GNT_D, "t4_d_arready");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check1($sformatf("t4_m_arvalid_%0d", k), bus.m_arvalid, 1'b1);
            check64($sformatf("t4_m_ar_addr_%0d", k), bus.m_ar.addr, ar_d.addr);
            check64($sformatf("t4_m_ar_len_%0d", k), 64'(bus.m_ar.len), 64'(ar_d.len));
            check1($sformatf("t4_i_arready_%0d", k), bus.i_arready, 1'b0);
        end
        ar_wait = 0;
        wait_drain("t4_drain");

        // I drops rready for 3 cycles mid-burst
        ar_i = mk_ar(64'hA000, 8'd3);
        @(negedge clk);
        #1;
        push_burst(GNT_I, ar_i, 4);
        i_req_q.push_back(ar_i);
        wait_exp_size(3, "t5_first_beat");
        #1 bus.i_rready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check1($sformatf("t5_m_rready_%0d", k), bus.m_rready, 1'b0);
            check1($sformatf("t5_i_rvalid_%0d", k), bus.i_rvalid, 1'b1);
        end
        @(posedge clk);
        #1 bus.i_rready = 1'b1;
        wait_drain("t5_drain");
        check1("t5_no_err", bus.protocol_err, 1'b0);

        // Early rlast: len 3, rlast on the third beat
        force_last = 2;
        ar_i = mk_ar(64'hB000, 8'd3);
        @(negedge clk);
        #1;
        push_burst(GNT_I, ar_i, 3);
        i_req_q.push_back(ar_i);
        wait_drain("t6_drain");
        check1("t6_protocol_err", bus.protocol_err, 1'b1);
        check1("t6_idle", bus.icache_reading, 1'b0);
        force_last = -1;
        repeat (2) @(negedge clk);
        check1("t6_err_sticky", bus.protocol_err, 1'b1);

        // Reset in the middle of a burst
        ar_i = mk_ar(64'hC000, 8'd7);
        @(negedge clk);
        #1;
        push_burst(GNT_I, ar_i, 8);
        i_req_q.push_back(ar_i);
        wait_exp_size(5, "t7_some_beats");
        #1;
        reset        = 1'b1;
        bus.i_rready = 1'b0;
        exp_q.delete();
        i_req_q.delete();
        @(posedge clk);
        @(negedge clk);
        check1("t7_i_rvalid", bus.i_rvalid, 1'b0);
        check1("t7_d_rvalid", bus.d_rvalid, 1'b0);
        check1("t7_i_rlast", bus.i_rlast, 1'b0);
        check1("t7_m_arvalid", bus.m_arvalid, 1'b0);
        check1("t7_m_rready", bus.m_rready, 1'b0);
        check1("t7_i_arready", bus.i_arready, 1'b0);
        check1("t7_d_arready", bus.d_arready, 1'b0);
        check1("t7_icache_reading", bus.icache_reading, 1'b0);
        check1("t7_dcache_reading", bus.dcache_reading, 1'b0);
        check1("t7_protocol_err", bus.protocol_err, 1'b0);
        check1("t7_m_ar_zero", bus.m_ar == '0, 1'b1);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.i_rready = 1'b1;
        repeat (3) @(negedge clk);
        check1("t7_err_stays_clear", bus.protocol_err, 1'b0);
        check1("t7_still_idle", bus.icache_reading || bus.dcache_reading, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
